// File: rtl/spi_mnrch16.sv
// SPI mode-3 monarch: shifts one 16-bit command out MSB first while capturing the
// sensor's 16-bit reply. SCLK is clk/16 and comes straight from the divider MSB.
module spi_mnrch16 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wrt,
  input  logic [15:0] i_wt_data,
  input  logic        i_miso,
  output logic        o_ss_n,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_done,
  output logic [15:0] o_rd_data
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] DIV_PRELOAD = 4'b1011;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_shft_reg;
  logic [3:0]  r_sclk_div;
  logic        r_miso_smpl;
  logic [4:0]  r_shft_cnt;
  logic        r_smpl_taken;
  logic        r_ss_n;
  logic        r_done;

  logic        w_load;
  logic        w_smpl;
  logic        w_shift;
  logic        w_finish;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The first div==15 after start is the end of the front porch: nothing has been
  // sampled yet, so r_smpl_taken gates the shift until the first SCLK rise.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_smpl       = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_wrt) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_smpl   = (r_sclk_div == 4'd7);
        w_shift  = (r_sclk_div == 4'd15) && r_smpl_taken;
        w_finish = w_shift && (r_shft_cnt == 5'd15);
        if (w_finish) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shft_reg   <= 16'h0000;
      r_sclk_div   <= DIV_PRELOAD;
      r_miso_smpl  <= 1'b0;
      r_shft_cnt   <= 5'd0;
      r_smpl_taken <= 1'b0;
      r_ss_n       <= 1'b1;
      r_done       <= 1'b0;
    end else if (w_load) begin
      r_shft_reg   <= i_wt_data;
      r_sclk_div   <= DIV_PRELOAD;
      r_shft_cnt   <= 5'd0;
      r_smpl_taken <= 1'b0;
      r_ss_n       <= 1'b0;
      r_done       <= 1'b0;
    end else if (r_state == SHIFT) begin
      // Reloading the preload on the last shift keeps SCLK high: no trailing fall.
      r_sclk_div <= w_finish ? DIV_PRELOAD : r_sclk_div + 4'd1;
      if (w_smpl) begin
        r_miso_smpl  <= i_miso;
        r_smpl_taken <= 1'b1;
      end
      if (w_shift) begin
        r_shft_reg <= {r_shft_reg[14:0], r_miso_smpl};
        r_shft_cnt <= r_shft_cnt + 5'd1;
      end
      if (w_finish) begin
        r_ss_n <= 1'b1;
        r_done <= 1'b1;
      end
    end
  end

  assign o_ss_n    = r_ss_n;
  assign o_sclk    = r_sclk_div[3];
  assign o_mosi    = r_shft_reg[15];
  assign o_done    = r_done;
  assign o_rd_data = r_shft_reg;

endmodule

// File: tb/tb_spi_mnrch16.sv
// Directed plus randomized bench for spi_mnrch16 with a cycle-level sensor model
// that answers on SCLK falls and records MOSI at SCLK rises.
module tb_spi_mnrch16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt;
  logic [15:0] wt_data;
  logic        miso;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  logic        done;
  logic [15:0] rd_data;

  spi_mnrch16 dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wrt     (wrt),
    .i_wt_data (wt_data),
    .i_miso    (miso),
    .o_ss_n    (ss_n),
    .o_sclk    (sclk),
    .o_mosi    (mosi),
    .o_done    (done),
    .o_rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Sensor model state
  logic [15:0] sens_word = 16'h0000;
  logic        porch_val = 1'b0;
  logic        idle_val  = 1'b0;
  logic        prev_sclk;
  logic        prev_ss_n;
  int          fall_cnt = 0;
  int          rise_cnt = 0;
  int          edge_cnt = 0;
  logic [15:0] mosi_cap = 16'h0000;

  // Observed mid-cycle: bit n of the reply appears after the (16-n)th SCLK fall.
  always @(negedge clk) begin
    if (prev_ss_n === 1'b1 && ss_n === 1'b0) begin
      fall_cnt = 0;
      rise_cnt = 0;
      mosi_cap = 16'h0000;
    end
    if (prev_sclk === 1'b1 && sclk === 1'b0) begin
      edge_cnt++;
      fall_cnt++;
    end
    if (prev_sclk === 1'b0 && sclk === 1'b1) begin
      edge_cnt++;
      rise_cnt++;
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    if (ss_n !== 1'b0)
      miso = idle_val;
    else if (fall_cnt == 0)
      miso = porch_val;
    else if (fall_cnt <= 16)
      miso = sens_word[16 - fall_cnt];
    else
      miso = idle_val;
    prev_sclk = sclk;
    prev_ss_n = ss_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer in the current cycle and returns in the cycle done is seen.
  task automatic xfer(input logic [15:0] wd, input logic [15:0] rep, input bit pulse_ign,
                      input string tag);
    int lat;
    sens_word = rep;
    wrt       = 1'b1;
    wt_data   = wd;
    tick();
    wrt = 1'b0;
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k == 1) begin
        chk({tag, " c1 ss_n"}, ss_n, 1'b0);
        chk({tag, " c1 sclk"}, sclk, 1'b1);
        chk({tag, " c1 mosi"}, mosi, wd[15]);
        chk({tag, " c1 done"}, done, 1'b0);
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      wrt = pulse_ign && (k == 50 || k == 200);
      if (wrt) wt_data = ~wd;
      tick();
    end
    wrt = 1'b0;
    chk({tag, " latency"}, lat, 262);
    chk({tag, " rd_data"}, rd_data, rep);
    chk({tag, " mosi bits"}, mosi_cap, wd);
    chk({tag, " sclk rises"}, rise_cnt, 16);
    chk({tag, " sclk falls"}, fall_cnt, 16);
    chk({tag, " end ss_n"}, ss_n, 1'b1);
    chk({tag, " end sclk"}, sclk, 1'b1);
    $display("xfer %s: wt=0x%04h reply=0x%04h rd=0x%04h latency=%0d", tag, wd, rep, rd_data, lat);
  endtask

  initial begin
    int          e0;
    logic [15:0] wd;
    logic [15:0] rep;

    rst = 1'b1;
    wrt = 1'b0;
    wt_data = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    e0 = edge_cnt;
    repeat (20) tick();
    chk("idle ss_n", ss_n, 1'b1);
    chk("idle sclk", sclk, 1'b1);
    chk("idle mosi", mosi, 1'b0);
    chk("idle done", done, 1'b0);
    chk("idle rd_data", rd_data, 16'h0000);
    chk("idle sclk edges", edge_cnt, e0);

    xfer(16'h0D02, 16'h00C3, 1'b0, "init0");
    repeat (3) tick();

    xfer(16'hA600, 16'h7F81, 1'b0, "yawL");
    xfer(16'hA700, 16'h0012, 1'b0, "yawH b2b");
    repeat (2) tick();

    xfer(16'h1160, 16'h3C5A, 1'b1, "wrt ignored");
    repeat (2) tick();

    // Reset in the middle of a transfer
    sens_word = 16'hBEEF;
    wrt = 1'b1;
    wt_data = 16'hF00D;
    tick();
    wrt = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    chk("rst ss_n", ss_n, 1'b1);
    chk("rst sclk", sclk, 1'b1);
    chk("rst done", done, 1'b0);
    chk("rst rd_data", rd_data, 16'h0000);
    chk("rst mosi", mosi, 1'b0);
    $display("reset at cycle 100: ss_n=%0b sclk=%0b done=%0b rd=0x%04h", ss_n, sclk, done, rd_data);
    rst = 1'b0;
    repeat (3) tick();
    xfer(16'h1440, 16'h9A6C, 1'b0, "post-rst");
    repeat (2) tick();

    porch_val = 1'b1;
    idle_val  = 1'b1;
    xfer(16'h0F0F, 16'h5555, 1'b0, "porch high");
    repeat (4) tick();

    for (int i = 0; i < 6; i++) begin
      wd        = 16'($urandom);
      rep       = 16'($urandom);
      porch_val = 1'($urandom_range(0, 1));
      idle_val  = 1'($urandom_range(0, 1));
      xfer(wd, rep, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mnrch16.md
# spi_mnrch16

16-bit SPI monarch (master) that serializes one command word to the inertial sensor and captures the sensor's simultaneous 16-bit reply. It sits directly upstream of the inertial sensor interface state machine. That block drives `wrt`/`wt_data` for init writes (0x0D02, 0x1160, 0x1440) and yaw reads (0xA6xx, 0xA7xx), then consumes `done`/`rd_data[7:0]`. SPI mode 3: SCLK idles high, MOSI changes on SCLK fall, MISO is sampled on SCLK rise.

## Interface
- No parameters. SCLK = clk/16, fixed.
- `clk`  in  1  system clock; all flops on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wrt`  in  1  start transaction; accepted only when idle.
- `wt_data`  in  16  command word; captured on the accepting edge; MSB first.
- `MISO`  in  1  serial data from sensor.
- `SS_n`  out  1  active-low select; low for the whole transaction.
- `SCLK`  out  1  serial clock, glitch-free (equals bit 3 of the divider flop).
- `MOSI`  out  1  serial data to sensor, equals `shft_reg[15]`.
- `done`  out  1  high from end of transaction until the next accepted `wrt`.
- `rd_data`  out  16  received word, equals `shft_reg`; valid while `done`=1.

## Operation
- Datapath:
  - 16-bit `shft_reg`.
  - 4-bit `sclk_div`.
  - 1-bit `MISO_smpl`.
  - 5-bit `shft_cnt`.
- States:
  - IDLE:
    - SS_n=1, SCLK=1, sclk_div held at 4'b1011.
    - On `wrt`: load `shft_reg<=wt_data`, `shft_cnt<=0`, `done<=0`, `SS_n<=0`, go to SHIFT.
  - SHIFT:
    - `sclk_div` increments every clk; SCLK=`sclk_div[3]`.
    - When `sclk_div==7`: `MISO_smpl<=MISO`. SCLK rises on the same edge.
    - When `sclk_div==15` and at least one sample has been taken since start: `shft_reg<={shft_reg[14:0],MISO_smpl}` and `shft_cnt++`. SCLK falls on the same edge.
    - When `sclk_div==15` with no sample taken yet (end of front porch): no shift.
    - On the 16th shift: `done<=1`, `SS_n<=1`, `sclk_div<=4'b1011` (SCLK held high), go to IDLE.
- Preloading 4'b1011 gives a 5-clk front porch (SS_n low, SCLK high) before the first fall.
- After completion there is no trailing SCLK fall; SCLK rises exactly 16 times and falls exactly 16 times per transaction.
- Bit order: `wt_data[15]` is on MOSI first. The first MISO bit received ends up in `rd_data[15]`.
- `wrt` while in SHIFT is ignored; no effect on data, counters or outputs.
- `wrt` in IDLE on the same cycle `done`=1 is accepted; `done` drops on that edge. This allows back-to-back transfers.
- `rst` has priority over everything, including mid-transaction:
  - state=IDLE, SS_n=1, SCLK=1, done=0.
  - shft_reg=0 (so MOSI=0 and rd_data=0).
  - sclk_div=4'b1011, shft_cnt=0, MISO_smpl=0.

## Timing
- Cycle 0: edge where `wrt` is accepted.
- Cycles 1–5: SS_n=0, SCLK=1, MOSI=`wt_data[15]`.
- Bit k (k=0..15):
  - SCLK low on cycles 6+16k … 13+16k.
  - SCLK high on cycles 14+16k … 21+16k.
  - MISO sampled on the edge ending cycle 13+16k.
  - MOSI shifts on the edge ending cycle 21+16k.
- Cycle 262: `done`=1, SS_n=1, SCLK=1, `rd_data` final.
- Latency: 262 clks from accept to `done`.
- Minimum repeat period: 262 clks. A new `wrt` can be accepted in cycle 262, which brings SS_n low again in cycle 263.
- MOSI is stable for ≥8 clks before and after each SCLK rise. The sensor must present MISO by each rise.
- `done` is a level, not a pulse. The consumer issues `wrt` in the `done` cycle or later.

## Test plan
- Reset, then idle 20 clks -> SS_n=1, SCLK=1, MOSI=0, done=0, rd_data=0x0000, no SCLK edges.
- `wrt` with `wt_data`=0x0D02; sensor model returns 0x00C3 -> MOSI bits captured at SCLK rises equal 0x0D02; rd_data=0x00C3; `done` rises exactly 262 clks after accept; exactly 16 SCLK rises.
- `wrt` with 0xA600; model returns 0x7F81 -> rd_data=0x7F81. Then, in the `done` cycle, `wrt` with 0xA700 and model returns 0x0012 -> done drops next cycle; second rd_data=0x0012; SS_n high for only the `done` cycle between the two transfers.
- `wrt` pulsed again at cycles 50 and 200 of a 0x1160 transfer -> ignored; timing and data identical to a clean transfer; a single `done` at cycle 262.
- `rst` asserted at cycle 100 of a transfer -> next cycle SS_n=1, SCLK=1, done=0, rd_data=0. A following 0x1440 transfer completes normally with correct data.
- MISO held at 1 during the front porch and after completion, with model data 0x5555 -> rd_data=0x5555; front-porch values are never sampled.
